time_lock_sequencer: RTL and testbench
======================================

// Module: time_lock_sequencer
// PURPOSE
//   Parametrised multi-stage time-lock sequencer for the vault phase chain.
//   On a start pulse, steps through NUM_STAGES lock stages. Each stage dwells
//   for a runtime-programmable number of cycles and drives a stage code.
//   Adds abort, hold (pause) with a hold watchdog, and a clear-to-rearm path.
//   Reports done/fail to the phase controller.
// PARAMETERS
//   NUM_STAGES  3   number of lock stages (>=1)
//   DWELL_W     4   width of dwell_cycles and of the stage timer
//   CODE_W      2   width of time_lock_out; must satisfy 2**CODE_W > NUM_STAGES
//   MAX_HOLD    8   consecutive hold cycles in RUN that force FAIL; 0 disables
// PORTS
//   clk            in   1        single clock, all logic on posedge
//   reset          in   1        synchronous, active-high
//   start          in   1        arm pulse; sampled only in IDLE
//   dwell_cycles   in   DWELL_W  per-stage dwell minus 1; latched on accepted start
//   hold           in   1        freezes the stage timer while high (RUN only)
//   abort          in   1        forces FAIL from RUN
//   clear          in   1        returns DONE/FAIL to IDLE
//   time_lock_out  out  CODE_W   current stage index 1..NUM_STAGES; 0 outside RUN
//   stage_tick     out  1        high on the first cycle of each stage
//   busy           out  1        high in RUN
//   phase_done     out  1        high while in DONE
//   phase_fail     out  1        high while in FAIL
// BEHAVIOUR
//   - States: IDLE, RUN, DONE, FAIL. Outputs are Moore-decoded from registered
//     state, stage, timer and tick flag; no input-to-output combinational paths.
//   - Reset (sync): state=IDLE, stage=0, timer=0, hold_cnt=0, dwell_lat=0.
//     All outputs are 0. Reset wins over every input, including mid-RUN.
//   - IDLE: start=1 -> latch dwell_lat=dwell_cycles. Next cycle: RUN, stage=1,
//     timer=0. Abort, hold and clear are ignored in IDLE.
//   - RUN, priority per cycle: abort > hold > count.
//       abort=1 -> FAIL next cycle (including in the final cycle of the last stage).
//       hold=1  -> timer frozen; hold_cnt++. When MAX_HOLD!=0 and
//                  hold_cnt reaches MAX_HOLD-1 while hold=1 -> FAIL next cycle.
//       hold=0  -> hold_cnt=0. If timer==dwell_lat: if stage==NUM_STAGES,
//                  go to DONE; else stage++ and timer=0. Otherwise timer++.
//   - Each stage lasts dwell_lat+1 non-held cycles. dwell_cycles=0 gives a
//     1-cycle stage. The timer never wraps because it stops at dwell_lat.
//   - Run latency with no hold: start on cycle 0, DONE on cycle
//     NUM_STAGES*(dwell_lat+1)+1.
//   - stage_tick: 1 on the first cycle with a new stage value (including
//     stage 1). Stays 1 if hold is asserted during that cycle. Never 1 outside RUN.
//   - start, and dwell_cycles changes, are ignored outside IDLE; dwell is fixed
//     for the whole run.
//   - DONE and FAIL are sticky. clear=1 -> IDLE next cycle. start is not
//     accepted in the same cycle as clear.
//   - busy=1 iff state==RUN. phase_done and phase_fail are never both 1.
//   - Illegal or unreachable state encoding -> FAIL next cycle.
// TESTING
//   1. Defaults, dwell=4, start @c0 -> out=1 c1-5, 2 c6-10, 3 c11-15;
//      phase_done=1 from c16; stage_tick on c1, c6, c11.
//   2. dwell=0, start -> stages 1,2,3 on c1, c2, c3; DONE c4; stage_tick=1 c1-3.
//   3. dwell=4, hold high c3-c5 (3 cycles) -> stage 1 extends to c8,
//      stage 2 starts c9, DONE c19, no FAIL.
//   4. MAX_HOLD=8, hold high from c2 continuously -> phase_fail=1 at c10;
//      out=0, busy=0.
//   5. abort @c7 (stage 2) -> FAIL c8. clear @c12 -> IDLE c13.
//      start @c13 -> stage 1 from c14.
//   6. reset pulse @c6 mid-RUN -> all outputs 0 at c7. start while RUN/DONE
//      is ignored; dwell_cycles change mid-run does not alter timing.

Source files
------------

// File: rtl/time_lock_sequencer.sv
// rtl/time_lock_sequencer.sv - multi-stage time-lock sequencer with abort, hold watchdog and clear-to-rearm
module time_lock_sequencer #(
    parameter int NUM_STAGES = 3,
    parameter int DWELL_W    = 4,
    parameter int CODE_W     = 2,
    parameter int MAX_HOLD   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell_cycles,
    input  logic               hold,
    input  logic               abort,
    input  logic               clear,
    output logic [CODE_W-1:0]  time_lock_out,
    output logic               stage_tick,
    output logic               busy,
    output logic               phase_done,
    output logic               phase_fail
);

    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [CODE_W-1:0] LAST_STAGE = CODE_W'(NUM_STAGES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t             state;
    logic [CODE_W-1:0]  stage;
    logic [DWELL_W-1:0] timer;
    logic [DWELL_W-1:0] dwell_lat;
    logic [HOLD_W-1:0]  hold_cnt;

    // Stage is forced to 0 whenever the sequencer leaves RUN, so it doubles as the output code.
    assign time_lock_out = stage;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            stage      <= '0;
            timer      <= '0;
            dwell_lat  <= '0;
            hold_cnt   <= '0;
            stage_tick <= 1'b0;
            busy       <= 1'b0;
            phase_done <= 1'b0;
            phase_fail <= 1'b0;
        end else begin
            stage_tick <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_RUN;
                        dwell_lat  <= dwell_cycles;
                        stage      <= CODE_W'(1);
                        timer      <= '0;
                        hold_cnt   <= '0;
                        stage_tick <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort || (hold && (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST))) begin
                        state      <= S_FAIL;
                        stage      <= '0;
                        timer      <= '0;
                        hold_cnt   <= '0;
                        busy       <= 1'b0;
                        phase_fail <= 1'b1;
                    end else if (hold) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end else begin
                        hold_cnt <= '0;
                        // Timer saturates at the latched dwell, so it can never wrap.
                        if (timer == dwell_lat) begin
                            timer <= '0;
                            if (stage == LAST_STAGE) begin
                                state      <= S_DONE;
                                stage      <= '0;
                                busy       <= 1'b0;
                                phase_done <= 1'b1;
                            end else begin
                                stage      <= stage + CODE_W'(1);
                                stage_tick <= 1'b1;
                            end
                        end else begin
                            timer <= timer + DWELL_W'(1);
                        end
                    end
                end
                S_DONE, S_FAIL: begin
                    if (clear) begin
                        state      <= S_IDLE;
                        phase_done <= 1'b0;
                        phase_fail <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_FAIL;
                    stage      <= '0;
                    timer      <= '0;
                    hold_cnt   <= '0;
                    busy       <= 1'b0;
                    phase_done <= 1'b0;
                    phase_fail <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_lock_sequencer.sv
// tb/tb_time_lock_sequencer.sv - scoreboard bench for time_lock_sequencer
module tb_time_lock_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] dwell_cycles;
    logic       hold;
    logic       abort;
    logic       clear;
    logic [1:0] time_lock_out;
    logic       stage_tick;
    logic       busy;
    logic       phase_done;
    logic       phase_fail;

    typedef struct packed {
        logic [1:0] code;
        logic       tick;
        logic       busy;
        logic       done;
        logic       fail;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    time_lock_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .dwell_cycles (dwell_cycles),
        .hold         (hold),
        .abort        (abort),
        .clear        (clear),
        .time_lock_out(time_lock_out),
        .stage_tick   (stage_tick),
        .busy         (busy),
        .phase_done   (phase_done),
        .phase_fail   (phase_fail)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs k cycles after an accepted start with no hold (3 stages).
    function automatic exp_t e_seq(input int k, input int d);
        exp_t e;
        e = '0;
        if (k >= 1 && k <= 3 * (d + 1)) begin
            e.code = 2'((k - 1) / (d + 1) + 1);
            e.tick = (((k - 1) % (d + 1)) == 0);
            e.busy = 1'b1;
        end else if (k > 3 * (d + 1)) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    function automatic exp_t e_fail();
        exp_t e;
        e = '0;
        e.fail = 1'b1;
        return e;
    endfunction

    task automatic cyc(input string tag, input exp_t e);
        exp_t x;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check_eq(tag, {26'd0, time_lock_out, stage_tick, busy, phase_done, phase_fail}, {26'd0, x});
    endtask

    task automatic idle_inputs();
        reset = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0; clear = 1'b0;
    endtask

    task automatic go_idle(input string tag);
        idle_inputs();
        clear = 1'b1;
        cyc(tag, '0);
        clear = 1'b0;
    endtask

    initial begin
        idle_inputs();
        dwell_cycles = 4'd4;
        reset = 1'b1;
        start = 1'b1;
        hold  = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset0", '0);
        cyc("reset1", '0);
        idle_inputs();
        hold = 1'b1; abort = 1'b1; clear = 1'b1;
        cyc("idle_ignore", '0);
        idle_inputs();

        // Defaults, dwell 4; start pulse during DONE must be ignored.
        dwell_cycles = 4'd4;
        for (int c = 0; c <= 18; c++) begin
            start = (c == 0 || c == 17);
            cyc($sformatf("t1_c%0d", c + 1), e_seq(c + 1, 4));
        end
        go_idle("t1_clr");

        // Single-cycle stages.
        dwell_cycles = 4'd0;
        for (int c = 0; c <= 5; c++) begin
            start = (c == 0);
            cyc($sformatf("t2_c%0d", c + 1), e_seq(c + 1, 0));
        end
        go_idle("t2_clr");

        // Three hold cycles stretch stage 1.
        dwell_cycles = 4'd4;
        for (int c = 0; c <= 20; c++) begin
            start = (c == 0);
            hold  = (c >= 3 && c <= 5);
            cyc($sformatf("t3_c%0d", c + 1), (c + 1 <= 5) ? e_seq(c + 1, 4) : e_seq(c + 1 - 3, 4));
        end
        go_idle("t3_clr");

        // Continuous hold trips the watchdog.
        dwell_cycles = 4'd4;
        for (int c = 0; c <= 12; c++) begin
            start = (c == 0);
            hold  = (c >= 2);
            cyc($sformatf("t4_c%0d", c + 1),
                (c + 1 == 1) ? e_seq(1, 4) : (c + 1 <= 9) ? e_seq(2, 4) : e_fail());
        end
        go_idle("t4_clr");

        // Abort in stage 2, clear, rearm; start during RUN and with clear is ignored.
        dwell_cycles = 4'd4;
        for (int c = 0; c <= 16; c++) begin
            int n;
            n = c + 1;
            start = (c == 0 || c == 3 || c == 12 || c == 13);
            abort = (c == 7 || c == 13);
            clear = (c == 12);
            cyc($sformatf("t5_c%0d", n),
                (n <= 7) ? e_seq(n, 4) : (n <= 12) ? e_fail() : (n == 13) ? exp_t'('0) : e_seq(n - 13, 4));
        end
        idle_inputs();
        abort = 1'b1;
        for (int c = 17; c <= 30; c++) begin
            cyc($sformatf("t5_c%0d", c + 1), e_fail());
        end
        go_idle("t5_clr");

        // Mid-run reset, dwell_cycles changed while running, then rearm with dwell 2.
        for (int c = 0; c <= 17; c++) begin
            int n;
            n = c + 1;
            start        = (c == 0 || c == 8);
            reset        = (c == 6);
            dwell_cycles = (c == 0) ? 4'd4 : (c >= 8) ? 4'd2 : 4'd0;
            cyc($sformatf("t6_c%0d", n), (n <= 6) ? e_seq(n, 4) : (n <= 8) ? exp_t'('0) : e_seq(n - 8, 2));
        end
        go_idle("t6_clr");

        // Abort on the final cycle of the last stage.
        dwell_cycles = 4'd0;
        for (int c = 0; c <= 4; c++) begin
            start = (c == 0);
            abort = (c == 3);
            cyc($sformatf("t7_c%0d", c + 1), (c + 1 <= 3) ? e_seq(c + 1, 0) : e_fail());
        end
        go_idle("t7_clr");

        // Seven holds (one short of the watchdog) starting on a stage's first cycle.
        dwell_cycles = 4'd0;
        for (int c = 0; c <= 11; c++) begin
            int n;
            n = c + 1;
            start = (c == 0);
            hold  = (c >= 2 && c <= 8);
            cyc($sformatf("t8_c%0d", n),
                (n <= 2) ? e_seq(n, 0) : (n <= 9) ? exp_t'({2'd2, 4'b0100}) : e_seq(n - 7, 0));
        end
        go_idle("t8_clr");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
